// File: rtl/keccak_pad_pkg.sv
// Shared constants, types and helpers for the Keccak block de-padder.
// Byte 0 of a word is bits [63:56]; byte 7 is bits [7:0].
package keccak_pad_pkg;
    localparam int         RATE_WORDS = 17;
    localparam logic [7:0] PAD_FIRST  = 8'h01;
    localparam logic [7:0] PAD_LAST   = 8'h80;

    typedef logic [4:0] word_idx_t;
    typedef logic [3:0] byte_cnt_t;

    typedef enum logic [1:0] {FILL, SCAN, EMIT} state_t;

    // Zero every byte at index >= k (k = 8 leaves the word intact).
    function automatic logic [63:0] mask_bytes(input logic [63:0] w, input byte_cnt_t k);
        logic [63:0] r;
        r = w;
        for (int b = 0; b < 8; b++) begin
            if (b >= int'(k)) r[63-8*b -: 8] = 8'h00;
        end
        return r;
    endfunction
endpackage

// File: rtl/keccak_pad_locate.sv
// Combinational pad finder: end word W, valid-byte count K of that word,
// and a flag for malformed pad10*1 padding on a final block.
module keccak_pad_locate
    import keccak_pad_pkg::*;
(
    input  logic [RATE_WORDS-1:0][63:0] blk_i,
    input  logic                        last_i,
    output word_idx_t                   w_o,
    output byte_cnt_t                   k_o,
    output logic                        bad_o
);
    logic [RATE_WORDS-1:0][63:0] clr;
    logic [63:0]                 ww;
    logic [7:0]                  pb;
    word_idx_t                   w;
    byte_cnt_t                   k;
    logic                        found;

    always_comb begin
        clr = blk_i;
        // Trailing pad bit removed so a 0x81 byte reduces to a plain 0x01 pad start.
        clr[RATE_WORDS-1][7:0] = blk_i[RATE_WORDS-1][7:0] & ~PAD_LAST;
        w     = word_idx_t'(RATE_WORDS-1);
        k     = 4'd8;
        found = 1'b0;
        ww    = '0;
        pb    = PAD_FIRST;
        if (last_i) begin
            for (int i = 0; i < RATE_WORDS; i++) begin
                if (clr[i] != '0) begin
                    w     = word_idx_t'(i);
                    found = 1'b1;
                end
            end
            ww = clr[w];
            k  = 4'd0;
            pb = 8'h00;
            for (int b = 0; b < 8; b++) begin
                if (ww[63-8*b -: 8] != 8'h00) begin
                    k  = byte_cnt_t'(b);
                    pb = ww[63-8*b -: 8];
                end
            end
        end
        w_o   = w;
        k_o   = k;
        bad_o = last_i && (!blk_i[RATE_WORDS-1][7] || !found || (pb != PAD_FIRST));
    end
endmodule

// File: rtl/keccak_depadder.sv
// Single-block buffer that passes non-final rate blocks through and strips
// pad10*1 from the final block, emitting message words with a byte count.
module keccak_depadder
    import keccak_pad_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] in,
    input  logic        in_ready,
    input  logic        is_last,
    output logic        buffer_full,
    output logic [63:0] out,
    output logic [3:0]  out_bytes,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ack,
    output logic        err
);
    logic [RATE_WORDS-1:0][63:0] blk_q;
    state_t    state_q;
    word_idx_t cnt_q, rd_q, w_q;
    byte_cnt_t k_q;
    logic      last_q, full_q, err_q;
    logic [63:0] out_q;
    byte_cnt_t out_bytes_q;
    logic      out_valid_q, out_last_q;

    word_idx_t loc_w;
    byte_cnt_t loc_k;
    logic      loc_bad;

    word_idx_t   ld_idx;
    logic        ld_end;
    logic [63:0] ld_word;
    byte_cnt_t   ld_bytes;
    logic        ld_last;

    logic accept;
    assign accept = in_ready && !full_q;

    keccak_pad_locate u_locate (
        .blk_i  (blk_q),
        .last_i (last_q),
        .w_o    (loc_w),
        .k_o    (loc_k),
        .bad_o  (loc_bad)
    );

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (accept) blk_q[cnt_q] <= in;
    end

    // Next word to present: the current one on the first load, else the following one.
    always_comb begin
        ld_idx   = out_valid_q ? word_idx_t'(rd_q + 5'd1) : rd_q;
        ld_end   = (ld_idx == w_q);
        ld_word  = ld_end ? mask_bytes(blk_q[ld_idx], k_q) : blk_q[ld_idx];
        ld_bytes = ld_end ? k_q : 4'd8;
        ld_last  = ld_end && last_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            rd_q        <= '0;
            w_q         <= '0;
            k_q         <= '0;
            last_q      <= 1'b0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            out_q       <= '0;
            out_bytes_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        cnt_q  <= word_idx_t'(cnt_q + 5'd1);
                        last_q <= last_q | is_last;
                        if (cnt_q == word_idx_t'(RATE_WORDS-1)) begin
                            state_q <= SCAN;
                            full_q  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (loc_bad) begin
                        err_q   <= 1'b1;
                        state_q <= FILL;
                        full_q  <= 1'b0;
                        cnt_q   <= '0;
                        last_q  <= 1'b0;
                    end else begin
                        w_q     <= loc_w;
                        k_q     <= loc_k;
                        rd_q    <= '0;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (!out_valid_q || out_ack) begin
                        if (out_valid_q && (rd_q == w_q)) begin
                            state_q     <= FILL;
                            full_q      <= 1'b0;
                            cnt_q       <= '0;
                            last_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                            out_q       <= '0;
                            out_bytes_q <= '0;
                            out_last_q  <= 1'b0;
                        end else begin
                            rd_q        <= ld_idx;
                            out_valid_q <= 1'b1;
                            out_q       <= ld_word;
                            out_bytes_q <= ld_bytes;
                            out_last_q  <= ld_last;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign buffer_full = full_q;
    assign out         = out_q;
    assign out_bytes   = out_bytes_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign err         = err_q;
endmodule

// File: tb/tb_keccak_depadder.sv
// Bench for keccak_depadder: directed block scenarios plus randomized
// blocks checked against a byte-level de-padding model.
module tb_keccak_depadder;
    import keccak_pad_pkg::*;
    localparam int RW = RATE_WORDS;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] in_d = '0;
    logic        in_ready = 1'b0;
    logic        is_last = 1'b0;
    logic        buffer_full;
    logic [63:0] out_d;
    logic [3:0]  out_bytes;
    logic        out_valid;
    logic        out_last;
    logic        out_ack = 1'b0;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic [63:0] blk [RW];
    logic [63:0] gw [$];
    int          gb [$];
    bit          gl [$];
    logic [63:0] ew [$];
    int          eb [$];
    bit          el [$];
    bit          e_err;
    bit          err_exp;

    keccak_depadder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in          (in_d),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .buffer_full (buffer_full),
        .out         (out_d),
        .out_bytes   (out_bytes),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ack     (out_ack),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic send_block(input bit fin);
        for (int i = 0; i < RW; i++) begin
            @(negedge clk);
            in_d = blk[i]; in_ready = 1'b1; is_last = fin;
        end
        @(negedge clk);
        in_d = '0; in_ready = 1'b0; is_last = 1'b0;
    endtask

    task automatic collect(input int n, input bit rnd_ack);
        int cyc;
        cyc = 0;
        gw.delete(); gb.delete(); gl.delete();
        while (gw.size() < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
            out_ack = rnd_ack ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_valid && out_ack) begin
                gw.push_back(out_d); gb.push_back(int'(out_bytes)); gl.push_back(out_last);
            end
        end
        @(negedge clk);
        out_ack = 1'b0;
    endtask

    // Reference: flatten to a byte stream, strip pad10*1, re-chunk into words.
    task automatic model(input bit fin);
        logic [7:0]  m [RW*8];
        logic [63:0] w;
        int p, L, nw;
        ew.delete(); eb.delete(); el.delete();
        e_err = 1'b0;
        if (!fin) begin
            for (int i = 0; i < RW; i++) begin
                ew.push_back(blk[i]); eb.push_back(8); el.push_back(1'b0);
            end
            return;
        end
        for (int j = 0; j < RW*8; j++) m[j] = blk[j/8][63-8*(j%8) -: 8];
        if (m[RW*8-1][7] == 1'b0) begin e_err = 1'b1; return; end
        m[RW*8-1][7] = 1'b0;
        p = -1;
        for (int j = 0; j < RW*8; j++) if (m[j] != 8'h00) p = j;
        if (p < 0 || m[p] != 8'h01) begin e_err = 1'b1; return; end
        L  = p;
        nw = L/8 + 1;
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int b = 0; b < 8; b++) if (i*8+b < L) w[63-8*b -: 8] = m[i*8+b];
            ew.push_back(w); eb.push_back((i == nw-1) ? L%8 : 8); el.push_back(i == nw-1);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        tests++;
        if ({out_valid, out_d, out_bytes, out_last, buffer_full, err} !== 70'd0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b o=%h b=%0d l=%b bf=%b e=%b want all 0",
                     out_valid, out_d, out_bytes, out_last, buffer_full, err);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_final_short();
        for (int i = 0; i < RW; i++) blk[i] = '0;
        blk[0] = 64'h1234567890ABCD01;
        blk[RW-1] = 64'h80;
        send_block(1'b1);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || buffer_full !== 1'b1) begin
            fails++;
            $display("FAIL latency_scan: got v=%b bf=%b want v=0 bf=1", out_valid, buffer_full);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL latency_first: got v=%b want 1", out_valid);
        end
        collect(1, 1'b0);
        tests++;
        if (gw.size() != 1 || gw[0] !== 64'h1234567890ABCD00 || gb[0] != 7 || gl[0] != 1'b1) begin
            fails++;
            $display("FAIL final_short: got n=%0d w=%h b=%0d l=%b want n=1 w=1234567890abcd00 b=7 l=1",
                     gw.size(), gw.size() ? gw[0] : 64'h0, gb.size() ? gb[0] : -1, gl.size() ? gl[0] : 1'b0);
        end
        tests++;
        if (out_valid !== 1'b0 || buffer_full !== 1'b0 || err !== err_exp) begin
            fails++;
            $display("FAIL final_short_idle: got v=%b bf=%b e=%b want v=0 bf=0 e=%b",
                     out_valid, buffer_full, err, err_exp);
        end
    endtask

    task automatic test_nonfinal();
        for (int i = 0; i < RW; i++) blk[i] = 64'(i+1);
        send_block(1'b0);
        collect(RW, 1'b0);
        tests++;
        if (gw.size() != RW) begin
            fails++;
            $display("FAIL nonfinal_count: got %0d want %0d", gw.size(), RW);
        end
        for (int i = 0; i < gw.size(); i++) begin
            tests++;
            if (gw[i] !== 64'(i+1) || gb[i] != 8 || gl[i] != 1'b0) begin
                fails++;
                $display("FAIL nonfinal_word%0d: got w=%h b=%0d l=%b want w=%h b=8 l=0",
                         i, gw[i], gb[i], gl[i], 64'(i+1));
            end
        end
        tests++;
        if (buffer_full !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL nonfinal_release: got bf=%b v=%b want 0 0", buffer_full, out_valid);
        end
    endtask

    task automatic test_boundary_81();
        for (int i = 0; i < RW-1; i++) blk[i] = '1;
        blk[RW-1] = 64'hAABBCCDDEEFF0081;
        send_block(1'b1);
        collect(RW, 1'b0);
        tests++;
        if (gw.size() != RW) begin
            fails++;
            $display("FAIL boundary_count: got %0d want %0d", gw.size(), RW);
        end else begin
            for (int i = 0; i < RW-1; i++) begin
                tests++;
                if (gw[i] !== '1 || gb[i] != 8 || gl[i] != 1'b0) begin
                    fails++;
                    $display("FAIL boundary_word%0d: got w=%h b=%0d l=%b want all-ones b=8 l=0",
                             i, gw[i], gb[i], gl[i]);
                end
            end
            tests++;
            if (gw[RW-1] !== 64'hAABBCCDDEEFF0000 || gb[RW-1] != 7 || gl[RW-1] != 1'b1) begin
                fails++;
                $display("FAIL boundary_last: got w=%h b=%0d l=%b want aabbccddeeff0000 b=7 l=1",
                         gw[RW-1], gb[RW-1], gl[RW-1]);
            end
        end
    endtask

    task automatic test_empty();
        for (int i = 0; i < RW; i++) blk[i] = '0;
        blk[0] = 64'h0100000000000000;
        blk[RW-1] = 64'h80;
        send_block(1'b1);
        collect(1, 1'b0);
        tests++;
        if (gw.size() != 1 || gw[0] !== 64'h0 || gb[0] != 0 || gl[0] != 1'b1) begin
            fails++;
            $display("FAIL empty_msg: got n=%0d w=%h b=%0d l=%b want n=1 w=0 b=0 l=1",
                     gw.size(), gw.size() ? gw[0] : 64'h0, gb.size() ? gb[0] : -1, gl.size() ? gl[0] : 1'b0);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL empty_single: got v=%b after one word want 0", out_valid);
        end
    endtask

    task automatic test_stall_reset();
        logic [69:0] snap;
        int n, cyc;
        for (int i = 0; i < RW; i++) blk[i] = 64'(i+1);
        send_block(1'b0);
        n = 0; cyc = 0;
        while (n < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            out_ack = out_valid;
            if (out_valid) n++;
        end
        @(negedge clk);
        out_ack = 1'b0;
        snap = {out_valid, out_d, out_bytes, out_last};
        tests++;
        if (snap !== {1'b1, 64'd4, 4'd8, 1'b0}) begin
            fails++;
            $display("FAIL stall_word: got %h want %h", snap, {1'b1, 64'd4, 4'd8, 1'b0});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if ({out_valid, out_d, out_bytes, out_last} !== snap) begin
                fails++;
                $display("FAIL stall_hold%0d: got %h want %h", c, {out_valid, out_d, out_bytes, out_last}, snap);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_d, out_bytes, out_last, buffer_full} !== 70'd0) begin
            fails++;
            $display("FAIL reset_mid_emit: got v=%b o=%h b=%0d l=%b bf=%b want all 0",
                     out_valid, out_d, out_bytes, out_last, buffer_full);
        end
        @(negedge clk);
        reset_n = 1'b1;
        err_exp = 1'b0;
        test_final_short();
    endtask

    task automatic test_error();
        bit saw_v;
        for (int i = 0; i < RW; i++) blk[i] = '0;
        blk[0] = 64'h1234567890ABCD01;
        send_block(1'b1);
        saw_v = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            saw_v |= out_valid;
        end
        tests++;
        if (saw_v !== 1'b0 || err !== 1'b1 || buffer_full !== 1'b0) begin
            fails++;
            $display("FAIL error_block: got saw_v=%b e=%b bf=%b want 0 1 0", saw_v, err, buffer_full);
        end
        err_exp = 1'b1;
        test_final_short();
    endtask

    task automatic test_random();
        logic [7:0] m [RW*8];
        bit fin, saw_v;
        int L;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        err_exp = 1'b0;
        for (int it = 0; it < 40; it++) begin
            fin = ($urandom_range(0, 3) != 0);
            if (!fin) begin
                for (int i = 0; i < RW; i++) blk[i] = {$urandom, $urandom};
            end else begin
                L = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(0, RW*8-1);
                for (int j = 0; j < RW*8; j++) m[j] = (j < L) ? 8'($urandom) : 8'h00;
                m[L] = 8'h01;
                m[RW*8-1] = m[RW*8-1] | 8'h80;
                case ($urandom_range(0, 7))
                    0: m[RW*8-1] = m[RW*8-1] & 8'h7F;
                    1: m[L] = (m[L] & 8'h80) | 8'h03;
                    default: ;
                endcase
                for (int i = 0; i < RW; i++)
                    for (int b = 0; b < 8; b++) blk[i][63-8*b -: 8] = m[i*8+b];
            end
            model(fin);
            send_block(fin);
            if (e_err) begin
                err_exp = 1'b1;
                saw_v = 1'b0;
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    saw_v |= out_valid;
                end
                tests++;
                if (saw_v !== 1'b0 || err !== 1'b1) begin
                    fails++;
                    $display("FAIL rand%0d_error: got saw_v=%b e=%b want 0 1", it, saw_v, err);
                end
            end else begin
                collect(ew.size(), 1'b1);
                tests++;
                if (gw.size() != ew.size() || out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL rand%0d_count: got %0d v=%b want %0d v=0", it, gw.size(), out_valid, ew.size());
                end else begin
                    for (int i = 0; i < ew.size(); i++) begin
                        tests++;
                        if (gw[i] !== ew[i] || gb[i] != eb[i] || gl[i] != el[i]) begin
                            fails++;
                            $display("FAIL rand%0d_word%0d: got w=%h b=%0d l=%b want w=%h b=%0d l=%b",
                                     it, i, gw[i], gb[i], gl[i], ew[i], eb[i], el[i]);
                        end
                    end
                end
                tests++;
                if (err !== err_exp || buffer_full !== 1'b0) begin
                    fails++;
                    $display("FAIL rand%0d_state: got e=%b bf=%b want e=%b bf=0", it, err, buffer_full, err_exp);
                end
            end
        end
    endtask

    initial begin
        err_exp = 1'b0;
        test_reset();
        test_final_short();
        test_nonfinal();
        test_boundary_81();
        test_empty();
        test_stall_reset();
        test_error();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
